// File: rtl/instruction_loader.sv
// Instruction loader: accepts a length-prefixed byte stream and writes
// big-endian 32-bit words into the instruction RAM, one word per WRITE cycle.
module instruction_loader #(
  parameter int RAM_DEPTH = 872
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [9:0]  i_ram_writing_address,
  output logic [31:0] i_ram_input,
  output logic        flag_write_i_ram,
  output logic        loading,
  output logic        load_done,
  output logic        load_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_BYTES,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  // Word counts are 10-bit quantities; the depth limit lives in the same width.
  localparam logic [9:0] LP_DEPTH = 10'(RAM_DEPTH);

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_len_hi;     // bits [9:8] of N, captured from the first header byte
  logic [9:0]  r_word_count; // N for the current session
  logic [9:0]  r_word_addr;  // address of the word being assembled
  logic [1:0]  r_byte_idx;   // position of the next byte inside the word
  logic [31:0] r_word;       // assembly register
  logic [9:0]  r_addr_out;   // RAM address presented to the RAM, held between writes
  logic [31:0] r_data_out;   // RAM data presented to the RAM, held between writes

  logic [9:0]  w_len;
  logic        w_len_bad;
  logic        w_last_word;
  logic [31:0] w_word_next;

  assign w_len       = {r_len_hi, byte_in};
  assign w_len_bad   = (w_len == 10'd0) || (w_len > LP_DEPTH);
  assign w_last_word = ((r_word_addr + 10'd1) == r_word_count);

  assign i_ram_writing_address = r_addr_out;
  assign i_ram_input           = r_data_out;

  // Place the incoming byte into the assembly word, most significant byte first.
  always_comb begin
    w_word_next = r_word;
    case (r_byte_idx)
      2'd0: w_word_next[31:24] = byte_in;
      2'd1: w_word_next[23:16] = byte_in;
      2'd2: w_word_next[15:8]  = byte_in;
      default: w_word_next[7:0] = byte_in;
    endcase
  end

  // State register.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and Moore outputs.
  // NOTE: every output is given a default first so no path leaves a value
  // unassigned and no latch is inferred.
  always_comb begin
    w_next           = r_state;
    byte_ready       = 1'b0;
    loading          = 1'b0;
    flag_write_i_ram = 1'b0;
    load_done        = 1'b0;
    load_error       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        byte_ready = 1'b1;
        loading    = 1'b1;
        if (byte_valid) w_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        byte_ready = 1'b1;
        loading    = 1'b1;
        if (byte_valid) w_next = w_len_bad ? S_ERROR : S_BYTES;
      end
      S_BYTES: begin
        byte_ready = 1'b1;
        loading    = 1'b1;
        if (byte_valid && (r_byte_idx == 2'd3)) w_next = S_WRITE;
      end
      S_WRITE: begin
        loading          = 1'b1;
        flag_write_i_ram = 1'b1;
        w_next           = w_last_word ? S_DONE : S_BYTES;
      end
      S_DONE: begin
        load_done = 1'b1;
        if (start) w_next = S_LEN_HI;
      end
      S_ERROR: begin
        load_error = 1'b1;
        if (start) w_next = S_LEN_HI;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: header capture, byte assembly, RAM address/data registers.
  // byte_ready is high exactly in LEN_HI/LEN_LO/BYTES, so byte_valid alone
  // qualifies a transfer inside those states.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_len_hi     <= '0;
      r_word_count <= '0;
      r_word_addr  <= '0;
      r_byte_idx   <= '0;
      r_word       <= '0;
      r_addr_out   <= '0;
      r_data_out   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            r_word_addr <= '0;
            r_byte_idx  <= '0;
          end
        end
        S_LEN_HI: begin
          if (byte_valid) r_len_hi <= byte_in[1:0];
        end
        S_LEN_LO: begin
          if (byte_valid) r_word_count <= w_len;
        end
        S_BYTES: begin
          if (byte_valid) begin
            r_word     <= w_word_next;
            r_byte_idx <= r_byte_idx + 2'd1;
            // The completed word is staged so it appears during WRITE.
            if (r_byte_idx == 2'd3) begin
              r_addr_out <= r_word_addr;
              r_data_out <= w_word_next;
            end
          end
        end
        S_WRITE: begin
          r_word_addr <= r_word_addr + 10'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: table-driven header cases,
// hand-written corner sequences and randomized sessions against a stream model.
module tb_instruction_loader;

  localparam int DEPTH = 872;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [9:0]  i_ram_writing_address;
  logic [31:0] i_ram_input;
  logic        flag_write_i_ram;
  logic        loading;
  logic        load_done;
  logic        load_error;

  instruction_loader #(.RAM_DEPTH(DEPTH)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .start                 (start),
    .byte_in               (byte_in),
    .byte_valid            (byte_valid),
    .byte_ready            (byte_ready),
    .i_ram_writing_address (i_ram_writing_address),
    .i_ram_input           (i_ram_input),
    .flag_write_i_ram      (flag_write_i_ram),
    .loading               (loading),
    .load_done             (load_done),
    .load_error            (load_error)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [7:0]  stim_q[$];    // header + payload offered to the DUT
  logic [7:0]  acc_q[$];     // bytes the DUT took
  int          acc_cyc[$];   // cycle each byte was taken
  logic [9:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  logic [9:0]  last_addr = '0;
  logic [31:0] last_data = '0;

  typedef struct {
    logic [7:0] hi;
    logic [7:0] lo;
    int         mode;     // 0: valid always, 1: toggling, 2: random
    logic       exp_err;
    int         exp_n;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int header_n(input logic [7:0] hi, input logic [7:0] lo);
    return int'({hi[1:0], lo});
  endfunction

  // One clock: sample outputs at the falling edge, then drive the next inputs.
  task automatic tick(input logic s, input logic v, input logic [7:0] b, output logic acc);
    @(negedge clock);
    cyc++;
    if (flag_write_i_ram) begin
      wr_addr_q.push_back(i_ram_writing_address);
      wr_data_q.push_back(i_ram_input);
      wr_cyc_q.push_back(cyc);
      check("write_ready_low", {63'd0, byte_ready}, 64'd0);
      last_addr = i_ram_writing_address;
      last_data = i_ram_input;
    end else begin
      check("ram_outputs_hold", {22'd0, i_ram_writing_address, i_ram_input},
            {22'd0, last_addr, last_data});
    end
    start      = s;
    byte_valid = v;
    byte_in    = b;
    acc = v && byte_ready;
    if (acc) begin
      acc_q.push_back(b);
      acc_cyc.push_back(cyc);
    end
  endtask

  task automatic clear_logs();
    acc_q.delete();
    acc_cyc.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
  endtask

  function automatic void build_stream(input logic [7:0] hi, input logic [7:0] lo, input int words);
    stim_q.delete();
    stim_q.push_back(hi);
    stim_q.push_back(lo);
    for (int i = 0; i < 4 * words; i++) stim_q.push_back(8'($urandom));
  endfunction

  // Start a session and stream stim_q until loading falls; glitch_idx >= 0
  // raises start once when that many bytes have been taken.
  task automatic run_session(input int mode, input int glitch_idx);
    logic       acc;
    logic       s;
    logic       v;
    logic [7:0] b;
    int         idx;
    int         budget;
    bit         glitched;
    bit         fin;
    idx = 0;
    glitched = 0;
    fin = 0;
    budget = 40 + 12 * stim_q.size();
    clear_logs();
    tick(1'b1, 1'b0, 8'h00, acc);
    tick(1'b0, 1'b0, 8'h00, acc);
    check("after_start", {60'd0, loading, byte_ready, load_done, load_error}, 64'b1100);
    for (int k = 0; k < budget && !fin; k++) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = k[0];
        default: v = 1'($urandom_range(0, 1));
      endcase
      s = 1'b0;
      if (idx == glitch_idx && !glitched) begin
        s = 1'b1;
        glitched = 1;
      end
      b = (idx < stim_q.size()) ? stim_q[idx] : 8'h5A;
      tick(s, v, b, acc);
      if (acc) idx++;
      if (!loading) fin = 1;
    end
    if (!fin) check("session_timeout", 64'd0, 64'd1);
    // Keep offering bytes after the session to show none are taken.
    for (int k = 0; k < 6; k++) tick(1'b0, 1'b1, 8'hC3, acc);
    tick(1'b0, 1'b0, 8'h00, acc);
  endtask

  // Reference: a valid session takes 2 + 4N bytes and writes word i, built
  // big-endian from payload bytes 4i..4i+3, to address i one cycle after its
  // last byte; a rejected header takes 2 bytes and writes nothing.
  task automatic verify(input logic exp_err, input int exp_n);
    int exp_acc;
    int exp_wr;
    exp_acc = exp_err ? 2 : 2 + 4 * exp_n;
    exp_wr  = exp_err ? 0 : exp_n;
    check("load_error", {63'd0, load_error}, {63'd0, exp_err});
    check("load_done", {63'd0, load_done}, {63'd0, !exp_err});
    check("idle_flags", {62'd0, loading, byte_ready}, 64'd0);
    check("bytes_taken", 64'(acc_q.size()), 64'(exp_acc));
    check("write_count", 64'(wr_addr_q.size()), 64'(exp_wr));
    for (int i = 0; i < exp_wr && i < wr_addr_q.size(); i++) begin
      check("write_addr", 64'(wr_addr_q[i]), 64'(i));
      check("write_data", 64'(wr_data_q[i]),
            {32'd0, stim_q[2+4*i], stim_q[3+4*i], stim_q[4+4*i], stim_q[5+4*i]});
      if (5 + 4 * i < acc_cyc.size())
        check("write_latency", 64'(wr_cyc_q[i]), 64'(acc_cyc[5+4*i] + 1));
    end
  endtask

  initial begin
    logic acc;
    int   idx;
    int   n;
    logic [7:0] hi;
    logic [7:0] lo;
    logic err;

    vecs[0] = '{8'h00, 8'h00, 0, 1'b1, 0};
    vecs[1] = '{8'h03, 8'h69, 0, 1'b1, 873};
    vecs[2] = '{8'h03, 8'h68, 0, 1'b0, 872};
    vecs[3] = '{8'hFD, 8'h02, 2, 1'b0, 258};
    vecs[4] = '{8'h03, 8'hFF, 1, 1'b1, 1023};
    vecs[5] = '{8'hFC, 8'h01, 1, 1'b0, 1};

    reset = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_in = 8'h00;
    #12;
    check("reset_outputs",
          {17'd0, byte_ready, loading, flag_write_i_ram, load_done, load_error,
           i_ram_writing_address, i_ram_input}, 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // No activity after reset release until start, even with bytes offered.
    clear_logs();
    for (int k = 0; k < 4; k++) tick(1'b0, 1'b1, 8'hFF, acc);
    check("idle_no_take", 64'(acc_q.size()), 64'd0);
    check("idle_not_loading", {63'd0, loading}, 64'd0);

    // Back-to-back two-word program.
    stim_q = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    run_session(0, -1);
    verify(1'b0, 2);
    if (wr_data_q.size() == 2) begin
      check("word0_const", 64'(wr_data_q[0]), 64'hDEADBEEF);
      check("word1_const", 64'(wr_data_q[1]), 64'h01234567);
    end

    // Header table: zero, over-depth, exact depth, ignored upper bits.
    foreach (vecs[i]) begin
      build_stream(vecs[i].hi, vecs[i].lo, vecs[i].exp_err ? 1 : vecs[i].exp_n);
      run_session(vecs[i].mode, -1);
      verify(vecs[i].exp_err, vecs[i].exp_n);
    end

    // Single word with byte_valid toggling every cycle.
    build_stream(8'h00, 8'h01, 1);
    run_session(1, -1);
    verify(1'b0, 1);

    // Start pulse while word 1 is being assembled is ignored.
    build_stream(8'h00, 8'h03, 3);
    run_session(0, 7);
    verify(1'b0, 3);

    // Reset after two bytes of word 2 of a four-word session.
    build_stream(8'h00, 8'h04, 4);
    clear_logs();
    tick(1'b1, 1'b0, 8'h00, acc);
    idx = 0;
    for (int k = 0; k < 20 && idx < 8; k++) begin
      tick(1'b0, 1'b1, stim_q[idx], acc);
      if (acc) idx++;
    end
    check("pre_reset_taken", 64'(idx), 64'd8);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("midsession_reset_outputs",
          {17'd0, byte_ready, loading, flag_write_i_ram, load_done, load_error,
           i_ram_writing_address, i_ram_input}, 64'd0);
    last_addr = '0;
    last_data = '0;
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b1, 8'h77, acc);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b1, 8'h77, acc);
    check("reset_write_count", 64'(wr_addr_q.size()), 64'd1);
    check("reset_bytes_taken", 64'(acc_q.size()), 64'd8);
    check("reset_idle", {62'd0, loading, byte_ready}, 64'd0);
    build_stream(8'h00, 8'h01, 1);
    run_session(0, -1);
    verify(1'b0, 1);

    // Randomized sessions, occasionally with an oversize header.
    for (int r = 0; r < 10; r++) begin
      if ($urandom_range(0, 3) == 0) begin
        hi = 8'h03;
        lo = 8'($urandom_range(8'h69, 8'hFF));
      end else begin
        hi = {6'($urandom), 2'b00};
        lo = 8'($urandom_range(1, 6));
      end
      n   = header_n(hi, lo);
      err = (n == 0) || (n > DEPTH);
      build_stream(hi, lo, err ? 1 : n);
      run_session(2, ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 6)) : -1);
      verify(err, n);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 SHALL have parameter RAM_DEPTH, default 872: number of instruction words the downstream RAM holds.
REQ-002 SHALL have ports: clock  input  1  sole clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 start  input  1  single-cycle request to begin a load session.
REQ-005 byte_in  input  8  program stream byte.
REQ-006 byte_valid  input  1  byte_in valid this cycle.
REQ-007 byte_ready  output  1  loader accepts byte_in this cycle.
REQ-008 i_ram_writing_address  output  10  RAM write address.
REQ-009 i_ram_input  output  32  RAM write data.
REQ-010 flag_write_i_ram  output  1  RAM write enable, one-cycle pulse per word.
REQ-011 loading  output  1  session in progress; downstream processor held while high.
REQ-012 load_done  output  1  last session completed successfully.
REQ-013 load_error  output  1  last session rejected due to an invalid length.

Function
REQ-014 A byte SHALL be transferred only on a rising edge where byte_valid and byte_ready are both high.
REQ-015 Stream format SHALL be: two header bytes carrying word count N (first byte bits [9:8] in its low 2 bits, upper 6 bits ignored; second byte bits [7:0]), then N words of 4 bytes each, most significant byte first.
REQ-016 States SHALL be IDLE, LEN_HI, LEN_LO, BYTES, WRITE, DONE, ERROR.
REQ-017 IDLE/DONE/ERROR: start=1 -> LEN_HI; clears load_done, load_error, word address and byte index; byte_ready=0 in these states.
REQ-018 LEN_HI: transfer -> LEN_LO. LEN_LO: transfer -> if N==0 or N>RAM_DEPTH then ERROR, else BYTES.
REQ-019 BYTES: each transfer shifts byte into 32-bit assembly register at position given by 2-bit byte index (0 -> [31:24] ... 3 -> [7:0]); fourth transfer -> WRITE.
REQ-020 WRITE: lasts exactly one cycle; flag_write_i_ram=1, i_ram_input = assembled word, i_ram_writing_address = current word address; byte_ready=0.
REQ-021 After WRITE: word address increments by 1; if words written == N -> DONE, else -> BYTES.
REQ-022 First word of every session SHALL be written to address 0; addresses strictly sequential, never exceeding RAM_DEPTH-1.
REQ-023 Latency: WRITE pulse SHALL occur in the cycle immediately after the 4th byte of a word is accepted; throughput max one word per 5 cycles.
REQ-024 byte_ready SHALL be high in LEN_HI, LEN_LO, BYTES only.
REQ-025 loading SHALL be high in LEN_HI, LEN_LO, BYTES, WRITE.
REQ-026 DONE: load_done=1; ERROR: load_error=1; each held until next start or reset.
REQ-027 start while loading=1 SHALL be ignored; session continues unaffected.
REQ-028 byte_valid while byte_ready=0 SHALL be ignored (no byte consumed).
REQ-029 flag_write_i_ram SHALL be 0 in every state except WRITE; i_ram_input and i_ram_writing_address hold last values outside WRITE.
REQ-030 Word count comparison SHALL use 10-bit unsigned arithmetic; N up to 1023 representable, values above RAM_DEPTH rejected.

Reset
REQ-031 On reset assertion, asynchronously: state IDLE, i_ram_writing_address=0, i_ram_input=0, flag_write_i_ram=0, byte_ready=0, loading=0, load_done=0, load_error=0, byte index=0.
REQ-032 Reset mid-session SHALL abort without further writes; a partially assembled word SHALL never be written.
REQ-033 After reset release, no activity until start.

Verification
REQ-034 start; bytes 00,02, DE,AD,BE,EF, 01,23,45,67 back-to-back -> writes 0xDEADBEEF@0, 0x01234567@1, each 1-cycle pulse one cycle after 4th byte; load_done=1, loading=0.
REQ-035 start; header 00,00 -> no write, load_error=1, byte_ready=0; header 03,69 (N=873) -> load_error=1; header 03,68 (N=872) accepted.
REQ-036 N=1 with byte_valid toggling 1/0 every cycle -> exactly 4 bytes consumed, single write of correct word at address 0, no extra bytes taken after DONE.
REQ-037 start pulse during BYTES of word 1 -> ignored; address sequence 0,1,2 unchanged for N=3.
REQ-038 reset asserted after 2 bytes of word 2 (N=4) -> all outputs to reset values same cycle, no write; new session rewrites from address 0.
REQ-039 Complete session, then second start with N=2 -> load_done clears on start, writes restart at address 0.
